mac_result_drain: RTL and testbench

MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

---
 rtl/mac_result_drain.sv | 161 ++++++++++++++++
 tb/tb_mac_result_drain.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_drain.sv
// Drains the MAC result matrix C in row-major order through a small output FIFO
// to a valid/ready downstream port, then pulses done for one cycle.
module mac_result_drain #(
    parameter int M                        = 8,
    parameter int N                        = 4,
    parameter int DATA_WIDTH_RESULT_MATRIX = 70,
    parameter int FIFO_DEPTH               = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                block2host_val,
    input  logic                                start_reading_result_matrix,
    output logic                                block2host_rdy,
    output logic [$clog2(M)-1:0]                ext_row_addr_c,
    output logic [$clog2(N)-1:0]                ext_col_addr_c,
    output logic                                ext_matrix_c_re,
    input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] ext_data_out_c,
    output logic                                done_reading_result_matrix,
    output logic                                out_val,
    input  logic                                out_rdy,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] out_data,
    output logic [$clog2(M)-1:0]                out_row,
    output logic [$clog2(N)-1:0]                out_col,
    output logic                                out_last
);

    localparam int RW = $clog2(M);
    localparam int CW = $clog2(N);
    localparam int DW = DATA_WIDTH_RESULT_MATRIX;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DW + RW + CW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          full;
    logic          push;
    logic          pop;
    logic          drain_empty;
    logic          last_addr;
    logic [EW-1:0] head;

    // Read enable, handshake and FIFO status decode
    always_comb begin
        full        = (count == (AW+1)'(FIFO_DEPTH));
        push        = (state == READ) && !full;
        pop         = (count != '0) && out_rdy;
        // Leaving DRAIN once the last entry is being popped lets done follow the final beat directly
        drain_empty = (count == {{AW{1'b0}}, pop});
        last_addr   = (row == RW'(M - 1)) && (col == CW'(N - 1));
        head        = mem[rd_ptr];
    end

    // Sequencer: state and row-major read address counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                    if (block2host_val && start_reading_result_matrix) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (push) begin
                        if (col == CW'(N - 1)) begin
                            col <= '0;
                            if (last_addr) begin
                                row   <= '0;
                                state <= DRAIN;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents are only observed through the occupancy-gated head
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ext_data_out_c, row, col};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Output port mapping; head fields read as zero while the FIFO is empty
    always_comb begin
        block2host_rdy             = (state == IDLE);
        done_reading_result_matrix = (state == DONE);
        ext_matrix_c_re            = push;
        ext_row_addr_c             = row;
        ext_col_addr_c             = col;
        out_val                    = (count != '0);
        if (out_val) begin
            out_data = head[EW-1 -: DW];
            out_row  = head[CW +: RW];
            out_col  = head[CW-1:0];
            out_last = (head[CW +: RW] == RW'(M - 1)) && (head[CW-1:0] == CW'(N - 1));
        end else begin
            out_data = '0;
            out_row  = '0;
            out_col  = '0;
            out_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain: expected beats queued at start, checked by a monitor.
module tb_mac_result_drain;

    localparam int M  = 8;
    localparam int N  = 4;
    localparam int DW = 70;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [2:0]    row;
        logic [1:0]    col;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          block2host_val = 1'b0;
    logic          start_reading_result_matrix = 1'b0;
    logic          block2host_rdy;
    logic [2:0]    ext_row_addr_c;
    logic [1:0]    ext_col_addr_c;
    logic          ext_matrix_c_re;
    logic [DW-1:0] ext_data_out_c;
    logic          done_reading_result_matrix;
    logic          out_val;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] out_data;
    logic [2:0]    out_row;
    logic [1:0]    out_col;
    logic          out_last;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    re_count = 0;
    int    done_cnt = 0;
    int    beats = 0;
    int    mode = 0;
    int    rdy_mode = 1;
    beat_t exp_q[$];

    mac_result_drain #(.M(M), .N(N), .DATA_WIDTH_RESULT_MATRIX(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .block2host_val(block2host_val),
        .start_reading_result_matrix(start_reading_result_matrix),
        .block2host_rdy(block2host_rdy),
        .ext_row_addr_c(ext_row_addr_c), .ext_col_addr_c(ext_col_addr_c),
        .ext_matrix_c_re(ext_matrix_c_re), .ext_data_out_c(ext_data_out_c),
        .done_reading_result_matrix(done_reading_result_matrix),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] cval(int md, int i, int j);
        if (md == 0) return DW'(42 * (4 + 2 * i));
        return (DW'(i + 1) << 60) | DW'(j * 13 + 5);
    endfunction

    assign ext_data_out_c = cval(mode, int'(ext_row_addr_c), int'(ext_col_addr_c));

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // out_rdy driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_rdy = 1'b0;
            else if (rdy_mode == 1) out_rdy = 1'b1;
            else out_rdy = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares each accepted beat with the scoreboard and checks stall stability
    initial begin
        logic  prev_stall;
        beat_t held;
        beat_t e;
        prev_stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (ext_matrix_c_re) re_count++;
                if (done_reading_result_matrix) done_cnt++;
                if (prev_stall) begin
                    check("stall_val", DW'(out_val), DW'(1));
                    check("stall_data", out_data, held.data);
                    check("stall_rowcol", DW'({out_row, out_col}), DW'({held.row, held.col}));
                end
                if (out_val && out_rdy) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", DW'(1), DW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_row", DW'(out_row), DW'(e.row));
                        check("beat_col", DW'(out_col), DW'(e.col));
                        check("beat_last", DW'(out_last), DW'(e.last));
                    end
                end
                prev_stall = out_val && !out_rdy;
                held = '{data: out_data, row: out_row, col: out_col, last: out_last};
            end
        end
    end

    task automatic queue_matrix();
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                exp_q.push_back('{data: cval(mode, i, j), row: 3'(i), col: 2'(j),
                                  last: (i == M - 1) && (j == N - 1)});
            end
        end
    endtask

    // Raise val/start for one sampling edge; returns the cycle index t they were seen in
    task automatic start_read(output int t);
        queue_matrix();
        block2host_val = 1'b1;
        start_reading_result_matrix = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        block2host_val = 1'b0;
        start_reading_result_matrix = 1'b0;
    endtask

    task automatic wait_done(int base, int bound);
        int n;
        n = 0;
        while (done_cnt == base && n < bound) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", DW'(done_cnt - base), DW'(1));
        check("queue_drained", DW'(exp_q.size()), DW'(0));
    endtask

    initial begin
        int t;
        int off;
        int base;
        int b0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_rdy", DW'(block2host_rdy), DW'(1));
        check("rst_re", DW'(ext_matrix_c_re), DW'(0));
        check("rst_addr", DW'({ext_row_addr_c, ext_col_addr_c}), DW'(0));
        check("rst_done", DW'(done_reading_result_matrix), DW'(0));
        check("rst_out_val", DW'(out_val), DW'(0));
        check("rst_out_data", out_data, DW'(0));
        check("rst_out_rowcol", DW'({out_row, out_col, out_last}), DW'(0));
        reset = 1'b0;

        // val without start stays idle
        block2host_val = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("val_only_rdy", DW'(block2host_rdy), DW'(1));
            check("val_only_re", DW'(ext_matrix_c_re), DW'(0));
        end
        block2host_val = 1'b0;

        // Full-rate drain with cycle-exact timing
        mode = 0;
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        base = done_cnt;
        b0 = beats;
        start_read(t);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            off = cyc - t;
            check("t_re", DW'(ext_matrix_c_re), DW'((off >= 1) && (off <= 32)));
            check("t_done", DW'(done_reading_result_matrix), DW'(off == 34));
            if (off <= 2) check("t_out_val", DW'(out_val), DW'(off >= 2));
            if (off == 2) check("t_first_data", out_data, DW'(168));
        end
        check("full_rate_done_cnt", DW'(done_cnt - base), DW'(1));
        check("full_rate_beats", DW'(beats - b0), DW'(32));
        check("full_rate_queue", DW'(exp_q.size()), DW'(0));

        // Backpressure: FIFO fills after four reads, address holds at (1,0)
        mode = 1;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        base = done_cnt;
        b0 = beats;
        re_count = 0;
        start_read(t);
        repeat (10) @(negedge clk);
        check("bp_reads", DW'(re_count), DW'(4));
        check("bp_re", DW'(ext_matrix_c_re), DW'(0));
        check("bp_addr", DW'({ext_row_addr_c, ext_col_addr_c}), DW'({3'd1, 2'd0}));
        check("bp_out_val", DW'(out_val), DW'(1));
        rdy_mode = 1;
        wait_done(base, 200);
        check("bp_beats", DW'(beats - b0), DW'(32));

        // Random backpressure
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        base = done_cnt;
        b0 = beats;
        start_read(t);
        wait_done(base, 2000);
        check("rand_beats", DW'(beats - b0), DW'(32));

        // Reset in the middle of a read
        mode = 0;
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        re_count = 0;
        start_read(t);
        off = 0;
        while (re_count < 10 && off < 100) begin
            @(negedge clk);
            off++;
        end
        check("midrst_reads_reached", DW'(re_count), DW'(10));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_idle", DW'(block2host_rdy), DW'(1));
        check("midrst_out_val", DW'(out_val), DW'(0));
        check("midrst_re", DW'(ext_matrix_c_re), DW'(0));
        check("midrst_addr", DW'({ext_row_addr_c, ext_col_addr_c}), DW'(0));
        mode = 1;
        base = done_cnt;
        b0 = beats;
        start_read(t);
        wait_done(base, 200);
        check("restart_beats", DW'(beats - b0), DW'(32));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
